// File: rtl/avg_unpool_unit.sv
// 2x2 average-unpooling / nearest-neighbour upsampler.
// ROW_A emits each value twice live; ROW_B replays the row from the line buffer.
module avg_unpool_unit #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 8,
    parameter int IN_H   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);

    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

    typedef enum logic {
        ROW_A,
        ROW_B
    } state_t;

    state_t state, state_n;
    logic [CW-1:0] col, col_n, wr_col;
    logic [RW-1:0] row, row_n;
    logic rep, rep_n;
    logic hold_valid, hold_valid_n;
    logic signed [DATA_W-1:0] hold;
    logic signed [DATA_W-1:0] line_buf [IN_W];
    logic signed [DATA_W-1:0] scaled;
    logic last_col, accept, xfer;

    assign last_col = (col == COL_LAST);
    assign scaled   = mode ? (in_data >>> 2) : in_data;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        unique case (state)
            ROW_A: begin
                in_ready  = !hold_valid || (out_ready && rep && !last_col);
                out_valid = hold_valid;
                out_data  = hold_valid ? hold : '0;
            end
            ROW_B: begin
                out_valid = 1'b1;
                out_data  = line_buf[col];
                out_last  = (row == ROW_LAST) && last_col && rep;
            end
            default: ;
        endcase
        // Outputs stay quiet for every cycle rst is held.
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_data  = '0;
            out_last  = 1'b0;
        end
    end

    always_comb begin
        state_n      = state;
        col_n        = col;
        row_n        = row;
        rep_n        = rep;
        hold_valid_n = hold_valid;
        wr_col       = col;
        unique case (state)
            ROW_A: begin
                if (xfer) begin
                    if (!rep) begin
                        rep_n = 1'b1;
                    end else if (last_col) begin
                        state_n      = ROW_B;
                        col_n        = '0;
                        rep_n        = 1'b0;
                        hold_valid_n = 1'b0;
                    end else begin
                        col_n        = col + CW'(1);
                        wr_col       = col + CW'(1);
                        hold_valid_n = 1'b0;
                    end
                end
                if (accept) begin
                    hold_valid_n = 1'b1;
                    rep_n        = 1'b0;
                end
            end
            ROW_B: begin
                if (xfer) begin
                    rep_n = !rep;
                    if (rep) begin
                        if (last_col) begin
                            state_n = ROW_A;
                            col_n   = '0;
                            row_n   = (row == ROW_LAST) ? '0 : row + RW'(1);
                        end else begin
                            col_n = col + CW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ROW_A;
            col        <= '0;
            row        <= '0;
            rep        <= 1'b0;
            hold_valid <= 1'b0;
            hold       <= '0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            rep        <= rep_n;
            hold_valid <= hold_valid_n;
            if (accept) begin
                hold <= scaled;
            end
        end
    end

    // Line buffer is not reset; contents are rewritten before every replay.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            line_buf[wr_col] <= scaled;
        end
    end

endmodule
